// File: rtl/la_ao311_bist.sv
// rtl/la_ao311_bist.sv - exhaustive 32-pattern BIST driver and checker for ao311/oa311 gates
// Drives {c0,b0,a2,a1,a0} = 0..31, compares z after LAT cycles, and reports count, first failure and pass.
module la_ao311_bist #(
  parameter     PROP = "DEFAULT",
  parameter     FUNC = "AO311",
  parameter int LAT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       b0,
  output logic       c0,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] errcnt,
  output logic [4:0] failvec,
  output logic       failvalid
);
  localparam bit IS_AO = (FUNC == "AO311");

  if (!((FUNC == "AO311") || (FUNC == "OA311")) || (PROP == "")) begin : g_bad_func
    $error("la_ao311_bist: FUNC must be AO311 or OA311");
  end
  if ((LAT < 0) || (LAT > 7)) begin : g_bad_lat
    $error("la_ao311_bist: LAT must be 0..7");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  state_t     state_nx;
  logic       start_q;
  logic       clear;
  logic [4:0] stim;
  logic [2:0] drain_cnt;
  logic       cmp_v;
  logic       cmp_e;
  logic [4:0] cmp_p;

  function automatic logic golden(input logic [4:0] s);
    if (IS_AO) return (s[0] & s[1] & s[2]) | s[3] | s[4];
    else       return (s[0] | s[1] | s[2]) & s[3] & s[4];
  endfunction

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_q) begin
          state_nx = RUN;
          clear    = 1'b1;
        end
      end
      RUN:     if (stim == 5'd31) state_nx = (LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == 3'd0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // start is registered so that a held start re-enters RUN after exactly one DONE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      stim      <= 5'd0;
      drain_cnt <= 3'd0;
    end else begin
      state   <= state_nx;
      start_q <= start;
      if ((state == RUN) && (state_nx == RUN)) stim <= stim + 5'd1;
      else                                     stim <= 5'd0;
      if (state == RUN)                               drain_cnt <= 3'(LAT - 1);
      else if ((state == DRAIN) && (drain_cnt != 3'd0)) drain_cnt <= drain_cnt - 3'd1;
    end
  end

  assign {c0, b0, a2, a1, a0} = stim;
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (errcnt == 6'd0);

  if (LAT == 0) begin : g_direct
    assign cmp_v = (state == RUN);
    assign cmp_e = golden(stim);
    assign cmp_p = stim;
  end else begin : g_dl
    logic [LAT-1:0] dv;
    logic [LAT-1:0] de;
    logic [4:0]     dp [LAT];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dv <= '0;
        de <= '0;
        for (int i = 0; i < LAT; i++) dp[i] <= 5'd0;
      end else begin
        dv[0] <= (state == RUN);
        de[0] <= golden(stim);
        dp[0] <= stim;
        for (int i = 1; i < LAT; i++) begin
          dv[i] <= dv[i-1];
          de[i] <= de[i-1];
          dp[i] <= dp[i-1];
        end
      end
    end

    assign cmp_v = dv[LAT-1];
    assign cmp_e = de[LAT-1];
    assign cmp_p = dp[LAT-1];
  end

  // case inequality so an unknown z counts as a mismatch in simulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt    <= 6'd0;
      failvec   <= 5'd0;
      failvalid <= 1'b0;
    end else if (clear) begin
      errcnt    <= 6'd0;
      failvec   <= 5'd0;
      failvalid <= 1'b0;
    end else if (cmp_v && (z !== cmp_e)) begin
      errcnt <= errcnt + 6'd1;
      if (!failvalid) begin
        failvec   <= cmp_p;
        failvalid <= 1'b1;
      end
    end
  end
endmodule
